// File: rtl/input_capture_unit.sv
// Debounced, handshaked capture of the switch bank for IN instructions.
// Stalls the core until a confirmed press, then requires a release before completing.
module input_capture_unit #(
    parameter int unsigned bits            = 32,
    parameter int unsigned swBits          = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned cntBits         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              request,
    input  logic              signExt,
    input  logic [swBits-1:0] switches,
    input  logic              button,
    output logic [bits-1:0]   IN,
    output logic              stall,
    output logic              ready
);

    localparam logic [cntBits-1:0] DB_TARGET = cntBits'(DEBOUNCE_CYCLES);
    localparam bit                 DB_ONE    = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_DEBOUNCE,
        S_WAIT_RELEASE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [cntBits-1:0]  r_cnt;
    logic [cntBits-1:0]  w_next_cnt;
    logic [cntBits-1:0]  w_cnt_inc;
    logic                r_ext_mode;
    logic                w_next_ext;
    logic                w_capture;
    logic [bits-1:0]     w_ext_val;

    logic                r_btn_meta;
    logic                r_btn_s;
    logic [swBits-1:0]   r_sw_meta;
    logic [swBits-1:0]   r_sw_s;

    logic [bits-1:0]     r_in;
    logic                r_stall;
    logic                r_ready;

    // Two-flop synchronizers for the asynchronous button and switch bank
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
        end else begin
            r_btn_meta <= button;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= switches;
            r_sw_s     <= r_sw_meta;
        end
    end

    assign w_cnt_inc = r_cnt + cntBits'(1);

    // Sign- or zero-extension of the synchronized switches
    always_comb begin
        w_ext_val               = '0;
        w_ext_val[swBits-1:0]   = r_sw_s;
        for (int unsigned i = swBits; i < bits; i++) begin
            w_ext_val[i] = r_ext_mode & r_sw_s[swBits-1];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_ext   = r_ext_mode;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (request) begin
                    w_next_state = S_WAIT_PRESS;
                    w_next_ext   = signExt;
                end
            end
            S_WAIT_PRESS: begin
                if (r_btn_s) begin
                    if (DB_ONE) begin
                        w_capture    = 1'b1;
                        w_next_state = S_WAIT_RELEASE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = S_DEBOUNCE;
                        w_next_cnt   = cntBits'(1);
                    end
                end
            end
            S_DEBOUNCE: begin
                if (!r_btn_s) begin
                    w_next_state = S_WAIT_PRESS;
                    w_next_cnt   = '0;
                end else if (w_cnt_inc == DB_TARGET) begin
                    w_capture    = 1'b1;
                    w_next_state = S_WAIT_RELEASE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = w_cnt_inc;
                end
            end
            S_WAIT_RELEASE: begin
                // Any bounce back to pressed restarts the release count
                if (r_btn_s) begin
                    w_next_cnt   = '0;
                end else if (w_cnt_inc == DB_TARGET) begin
                    w_next_state = S_DONE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = w_cnt_inc;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ext_mode <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_ext_mode <= w_next_ext;
        end
    end

    // Outputs registered from the next state so they track the state register exactly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in    <= '0;
            r_stall <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_stall <= (w_next_state == S_WAIT_PRESS) ||
                       (w_next_state == S_DEBOUNCE)   ||
                       (w_next_state == S_WAIT_RELEASE);
            r_ready <= (w_next_state == S_DONE);
            if (w_capture) begin
                r_in <= w_ext_val;
            end
        end
    end

    assign IN    = r_in;
    assign stall = r_stall;
    assign ready = r_ready;

endmodule

// File: tb/tb_input_capture_unit.sv
// Scoreboard bench for input_capture_unit: expected IN values queued per request,
// compared when ready pulses.
module tb_input_capture_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        request;
    logic        signExt;
    logic [15:0] switches;
    logic        button;
    logic [31:0] IN;
    logic        stall;
    logic        ready;

    logic [31:0] sb_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          ready_cnt = 0;
    int          n_done    = 0;
    logic        prev_stall = 1'b0;

    input_capture_unit #(
        .bits(32), .swBits(16), .DEBOUNCE_CYCLES(4), .cntBits(8)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .signExt(signExt),
        .switches(switches), .button(button), .IN(IN), .stall(stall), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic se, input logic [15:0] sw);
        return se ? {{16{sw[15]}}, sw} : {16'h0000, sw};
    endfunction

    // Output monitor: pop the scoreboard on every ready pulse
    always @(negedge clock) begin
        logic [31:0] exp_v;
        if (reset === 1'b1 && ready === 1'b1) begin
            ready_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("ready_unexpected", 32'(ready), 32'd0);
            end else begin
                exp_v = sb_q.pop_front();
                check_eq("in_value", IN, exp_v);
                check_eq("stall_with_ready", 32'(stall), 32'd0);
                check_eq("stall_before_ready", 32'(prev_stall), 32'd1);
            end
        end
        prev_stall = stall;
    end

    task automatic issue(input logic se, input logic [15:0] sw);
        @(negedge clock);
        switches = sw;
        signExt  = se;
        request  = 1'b1;
        sb_q.push_back(ext(se, sw));
        @(negedge clock);
        request = 1'b0;
        check_eq("stall_after_req", 32'(stall), 32'd1);
    endtask

    task automatic press(input int n);
        @(negedge clock);
        button = 1'b1;
        repeat (n) @(negedge clock);
        button = 1'b0;
    endtask

    task automatic wait_ready(input int target);
        for (int i = 0; i < 40 && ready_cnt < target; i++) @(posedge clock);
        check_eq("ready_count", 32'(ready_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        se_tab[3];
        logic [15:0] sw_tab[3];
        se_tab = '{1'b0, 1'b1, 1'b1};
        sw_tab = '{16'h8005, 16'h8005, 16'h7FFF};

        reset    = 1'b0;
        request  = 1'b0;
        signExt  = 1'b0;
        switches = 16'h0000;
        button   = 1'b0;
        #12;
        check_eq("rst_in", IN, 32'h0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic zero/sign extension captures
        for (int k = 0; k < 3; k++) begin
            issue(se_tab[k], sw_tab[k]);
            press(10);
            n_done++;
            wait_ready(n_done);
            @(negedge clock);
            check_eq("ready_one_cycle", 32'(ready), 32'd0);
            check_eq("stall_after_done", 32'(stall), 32'd0);
            check_eq("in_hold", IN, ext(se_tab[k], sw_tab[k]));
        end

        // Short glitches must not capture
        issue(1'b0, 16'hABCD);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            button = 1'b1;
            repeat (k) @(negedge clock);
            button = 1'b0;
            repeat (6) @(negedge clock);
        end
        check_eq("glitch_stall", 32'(stall), 32'd1);
        check_eq("glitch_in", IN, 32'h00007FFF);
        check_eq("glitch_ready", 32'(ready_cnt), 32'(n_done));
        press(10);
        n_done++;
        wait_ready(n_done);
        @(negedge clock);
        check_eq("after_glitch_in", IN, 32'h0000ABCD);

        // Switch change after capture is ignored
        issue(1'b0, 16'h5A5A);
        @(negedge clock);
        button = 1'b1;
        repeat (8) @(negedge clock);
        switches = 16'h1234;
        repeat (4) @(negedge clock);
        check_eq("sw_change_in", IN, 32'h00005A5A);
        check_eq("sw_change_stall", 32'(stall), 32'd1);
        button = 1'b0;
        n_done++;
        wait_ready(n_done);
        @(negedge clock);
        check_eq("sw_change_final", IN, 32'h00005A5A);

        // Held button: no completion until release; next request needs a new press
        issue(1'b1, 16'h0F0F);
        @(negedge clock);
        button = 1'b1;
        repeat (20) @(negedge clock);
        check_eq("held_stall", 32'(stall), 32'd1);
        check_eq("held_no_ready", 32'(ready_cnt), 32'(n_done));
        check_eq("held_in", IN, 32'h00000F0F);
        button = 1'b0;
        n_done++;
        wait_ready(n_done);
        issue(1'b0, 16'h00F0);
        repeat (10) @(negedge clock);
        check_eq("b2b_stall", 32'(stall), 32'd1);
        check_eq("b2b_no_ready", 32'(ready_cnt), 32'(n_done));
        check_eq("b2b_in_kept", IN, 32'h00000F0F);
        press(8);
        n_done++;
        wait_ready(n_done);
        @(negedge clock);
        check_eq("b2b_in", IN, 32'h000000F0);

        // Asynchronous reset while debouncing
        issue(1'b0, 16'h3C3C);
        @(negedge clock);
        button = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_stall", 32'(stall), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd0);
        check_eq("arst_in", IN, 32'h0);
        sb_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check_eq("post_rst_stall", 32'(stall), 32'd0);
        check_eq("post_rst_ready", 32'(ready_cnt), 32'(n_done));
        check_eq("post_rst_in", IN, 32'h0);
        button = 1'b0;
        repeat (4) @(negedge clock);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("total_ready", 32'(ready_cnt), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
